// File: rtl/pkwars_load_ctrl.sv
// ROM-download and core-reset sequencer for Penguin-Kun Wars: turns the hps_io
// ioctl stream into registered ROM write strobes, latches DIP bytes, owns core reset.
module pkwars_load_ctrl #(
  parameter logic [16:0] TOTAL_BYTES = 17'h1A020,
  parameter int unsigned HOLD_CYCLES = 48,
  parameter logic [63:0] DSW_DEFAULT = 64'h0
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        user_rst,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        rom_we,
  output logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [63:0] dsw,
  output logic        core_reset,
  output logic        loading,
  output logic        load_ok,
  output logic        load_err
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_ERROR
  } state_t;

  state_t            state_reg;
  logic [16:0]       byte_cnt_reg;
  logic              overflow_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              rom_we_reg;
  logic [16:0]       rom_addr_reg;
  logic [7:0]        rom_data_reg;
  logic              core_reset_reg;
  logic              loading_reg;
  logic              load_ok_reg;
  logic              load_err_reg;
  logic [7:0]        dsw_byte_reg [8];

  logic rom_dl;
  logic rom_wr;
  logic addr_in_range;
  logic enter_load;
  logic dsw_hit;

  assign rom_dl        = ioctl_download && (ioctl_index == 8'd0);
  assign rom_wr        = rom_dl && ioctl_wr;
  assign addr_in_range = ioctl_addr < {8'd0, TOTAL_BYTES};
  assign enter_load    = rom_dl && (state_reg != ST_LOAD);
  assign dsw_hit       = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0);

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_reg      <= ST_BOOT;
      byte_cnt_reg   <= '0;
      overflow_reg   <= 1'b0;
      hold_cnt_reg   <= '0;
      rom_we_reg     <= 1'b0;
      rom_addr_reg   <= '0;
      rom_data_reg   <= '0;
      core_reset_reg <= 1'b1;
      loading_reg    <= 1'b0;
      load_ok_reg    <= 1'b0;
      load_err_reg   <= 1'b0;
    end else begin
      rom_we_reg <= 1'b0;
      // A new ROM download pre-empts every other state, including the settle hold.
      if (enter_load) begin
        state_reg      <= ST_LOAD;
        byte_cnt_reg   <= '0;
        overflow_reg   <= 1'b0;
        load_ok_reg    <= 1'b0;
        load_err_reg   <= 1'b0;
        loading_reg    <= 1'b1;
        core_reset_reg <= 1'b1;
      end else begin
        case (state_reg)
          ST_LOAD: begin
            if (!ioctl_download) begin
              loading_reg <= 1'b0;
              if ((byte_cnt_reg == TOTAL_BYTES) && !overflow_reg) begin
                state_reg    <= ST_SETTLE;
                load_ok_reg  <= 1'b1;
                hold_cnt_reg <= HOLD_LOAD;
              end else begin
                state_reg    <= ST_ERROR;
                load_err_reg <= 1'b1;
              end
            end else if (rom_wr) begin
              if (addr_in_range) begin
                rom_we_reg   <= 1'b1;
                rom_addr_reg <= ioctl_addr[16:0];
                rom_data_reg <= ioctl_dout;
                if (byte_cnt_reg != 17'h1FFFF) begin
                  byte_cnt_reg <= byte_cnt_reg + 17'd1;
                end
              end else begin
                overflow_reg <= 1'b1;
              end
            end
          end
          ST_SETTLE: begin
            if (hold_cnt_reg == '0) begin
              state_reg      <= ST_RUN;
              core_reset_reg <= 1'b0;
            end else begin
              hold_cnt_reg <= hold_cnt_reg - 1'b1;
            end
          end
          ST_RUN: begin
            if (user_rst) begin
              state_reg      <= ST_SETTLE;
              core_reset_reg <= 1'b1;
              hold_cnt_reg   <= HOLD_LOAD;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // DIP bytes live outside the FSM: writable in any state, one lane per byte.
  for (genvar gi = 0; gi < 8; gi++) begin : g_dsw
    always_ff @(posedge clk_sys) begin
      if (RESET) begin
        dsw_byte_reg[gi] <= DSW_DEFAULT[gi*8 +: 8];
      end else if (dsw_hit && (ioctl_addr[2:0] == 3'(gi))) begin
        dsw_byte_reg[gi] <= ioctl_dout;
      end
    end
    assign dsw[gi*8 +: 8] = dsw_byte_reg[gi];
  end

  assign rom_we     = rom_we_reg;
  assign rom_addr   = rom_addr_reg;
  assign rom_data   = rom_data_reg;
  assign core_reset = core_reset_reg;
  assign loading    = loading_reg;
  assign load_ok    = load_ok_reg;
  assign load_err   = load_err_reg;

endmodule

// File: tb/tb_pkwars_load_ctrl.sv
// Directed/randomized bench for pkwars_load_ctrl with a download-outcome model
// (byte counts, range checks and a DIP byte array) kept independently of the RTL.
module tb_pkwars_load_ctrl;

  localparam logic [16:0] TB_TOTAL   = 17'd16;
  localparam int          TB_HOLD    = 4;
  localparam logic [63:0] TB_DSW_DEF = 64'h0123_4567_89AB_CDEF;

  logic        clk_sys = 1'b0;
  logic        RESET = 1'b1;
  logic        user_rst = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        rom_we;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic [63:0] dsw;
  logic        core_reset;
  logic        loading;
  logic        load_ok;
  logic        load_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_dsw [8];

  always #5 clk_sys = ~clk_sys;

  pkwars_load_ctrl #(
    .TOTAL_BYTES (TB_TOTAL),
    .HOLD_CYCLES (TB_HOLD),
    .DSW_DEFAULT (TB_DSW_DEF)
  ) dut (
    .clk_sys        (clk_sys),
    .RESET          (RESET),
    .user_rst       (user_rst),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .rom_we         (rom_we),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .dsw            (dsw),
    .core_reset     (core_reset),
    .loading        (loading),
    .load_ok        (load_ok),
    .load_err       (load_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [63:0] pack_dsw();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = exp_dsw[i];
    return v;
  endfunction

  task automatic reset_dsw_model();
    for (int i = 0; i < 8; i++) exp_dsw[i] = TB_DSW_DEF[i*8 +: 8];
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit exp_acc, input string tag);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
    $display("byte idx=%0d addr=%0h data=%02h expect_write=%0d rom_we=%0b", ioctl_index, a, d, exp_acc, rom_we);
    check({tag, " rom_we"}, rom_we, exp_acc);
    if (exp_acc) begin
      check({tag, " rom_addr"}, rom_addr, a[16:0]);
      check({tag, " rom_data"}, rom_data, d);
    end
  endtask

  // Counts the hold cycles after the edge that started SETTLE (or would have).
  task automatic expect_hold(input string tag, input bit releases);
    for (int k = 1; k < TB_HOLD; k++) begin
      step();
      check({tag, " core_reset held"}, core_reset, 1'b1);
    end
    step();
    check({tag, " core_reset end"}, core_reset, !releases);
  endtask

  task automatic finish_download(input bit ok, input string tag);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    step();
    $display("download end tag=%s expect_ok=%0d load_ok=%0b load_err=%0b", tag, ok, load_ok, load_err);
    check({tag, " load_ok"}, load_ok, ok);
    check({tag, " load_err"}, load_err, !ok);
    check({tag, " loading low"}, loading, 1'b0);
    check({tag, " core_reset t+1"}, core_reset, 1'b1);
    expect_hold(tag, ok);
  endtask

  task automatic run_download(input int n, input bit rand_data, input bit gaps, input string tag);
    int n_in;
    bit oob;
    bit acc;
    logic [24:0] a;
    logic [7:0] d;
    n_in = 0;
    oob  = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b0;
    step();
    check({tag, " loading rise"}, loading, 1'b1);
    check({tag, " flags cleared"}, {load_ok, load_err}, 2'b00);
    for (int i = 0; i < n; i++) begin
      a   = 25'(i);
      d   = rand_data ? 8'($urandom) : (a[7:0] ^ 8'hA5);
      acc = (a < 25'(TB_TOTAL));
      if (acc) n_in++;
      else oob = 1'b1;
      send_byte(a, d, acc, tag);
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        step();
        check({tag, " gap no rom_we"}, rom_we, 1'b0);
      end
    end
    finish_download((n_in == int'(TB_TOTAL)) && !oob, tag);
  endtask

  task automatic dip_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_index = idx;
    ioctl_wr    = 1'b1;
    ioctl_addr  = a;
    ioctl_dout  = d;
    step();
    ioctl_wr = 1'b0;
    if ((idx == 8'd254) && (a < 25'd8)) exp_dsw[a[2:0]] = d;
    $display("dip idx=%0d addr=%0h data=%02h dsw=%016h", idx, a, d, dsw);
    check("dip dsw", dsw, pack_dsw());
    check("dip no rom_we", rom_we, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_dsw_model();
    // 1: reset, then idle in BOOT
    repeat (3) step();
    RESET = 1'b0;
    repeat (20) step();
    check("rst core_reset", core_reset, 1'b1);
    check("rst loading", loading, 1'b0);
    check("rst flags", {load_ok, load_err}, 2'b00);
    check("rst rom_we", rom_we, 1'b0);
    check("rst rom_addr", rom_addr, 17'd0);
    check("rst rom_data", rom_data, 8'd0);
    check("rst dsw", dsw, pack_dsw());

    // 2: good download, addr ^ A5 data, back to back
    run_download(16, 1'b0, 1'b0, "good0");

    // 3: short, long, then a good download with random data and gaps
    run_download(15, 1'b1, 1'b0, "short");
    run_download(17, 1'b1, 1'b0, "long");
    run_download(16, 1'b1, 1'b1, "good1");

    // 4: user_rst pulse, then user_rst held through SETTLE
    user_rst = 1'b1;
    step();
    user_rst = 1'b0;
    check("urst pulse start", core_reset, 1'b1);
    expect_hold("urst pulse", 1'b1);
    user_rst = 1'b1;
    step();
    check("urst held start", core_reset, 1'b1);
    for (int k = 1; k < TB_HOLD; k++) begin
      step();
      check("urst held hold", core_reset, 1'b1);
    end
    user_rst = 1'b0;
    step();
    check("urst held end", core_reset, 1'b0);
    step();
    check("urst held run", core_reset, 1'b0);

    // 5: DIP writes during RUN, including out-of-window and random ones
    dip_write(8'd254, 25'd0, 8'h3C);
    dip_write(8'd254, 25'd9, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      dip_write(8'd254, 25'($urandom_range(0, 15)), 8'($urandom));
    end
    dip_write(8'd7, 25'd2, 8'h55);
    check("dip run core_reset", core_reset, 1'b0);
    check("dip run loading", loading, 1'b0);

    // ignored writes in RUN: index 7 during download, index 0 with download low
    ioctl_index    = 8'd7;
    ioctl_download = 1'b1;
    send_byte(25'd2, 8'h11, 1'b0, "idx7");
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    send_byte(25'd5, 8'h22, 1'b0, "idx0 nodl run");
    check("ignored core_reset", core_reset, 1'b0);

    // 6: RESET after 8 bytes, download keeps going
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    step();
    check("abort loading", loading, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(25'(i), 8'($urandom), 1'b1, "abort pre");
    RESET = 1'b1;
    send_byte(25'd8, 8'($urandom), 1'b0, "abort rst");
    RESET = 1'b0;
    reset_dsw_model();
    check("abort core_reset", core_reset, 1'b1);
    check("abort loading low", loading, 1'b0);
    check("abort load_ok", load_ok, 1'b0);
    check("abort dsw default", dsw, pack_dsw());
    send_byte(25'd9, 8'($urandom), 1'b0, "abort boot");
    check("abort reload", loading, 1'b1);
    for (int i = 10; i < 16; i++) send_byte(25'(i), 8'($urandom), 1'b1, "abort post");
    finish_download(1'b0, "abort");

    // index-0 write with download low, now in ERROR
    send_byte(25'd3, 8'h77, 1'b0, "idx0 nodl err");
    check("err loading", loading, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
